aging_priority_arbiter: RTL

- Parametrised successor to the single-cycle fair priority arbiter: N requesters, each with a base priority.
- Adds per-requester aging counters. A requester that has waited AGE_THRESHOLD cycles is boosted above every un-aged requester, so it cannot starve.
- Adds an optional lock mode: a grant is held until the holder raises release or drops its request.
- Ties are broken round-robin from the last grant. Sits in front of shared buses and resources in the arbiters library.

---
 rtl/fair_arb_pkg.sv | 21 ++
 rtl/rr_max_select.sv | 44 ++++
 rtl/aging_priority_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fair_arb_pkg.sv
// Shared definitions for the fair/aging arbiter family: state encoding and index helpers.
package fair_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StHold = ST_HOLD
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_max_select.sv
// Combinational max-priority selector; ties resolve to the first match scanning from start_idx.
module rr_max_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned EFF_W = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]       request,
  input  logic [N*EFF_W-1:0] eff,
  input  logic [IDX_W-1:0]   start_idx,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [EFF_W-1:0] eff_arr [N];
  logic [IDX_W:0]   scan_sum;
  logic [IDX_W-1:0] scan_idx;
  logic [EFF_W-1:0] best_eff;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign eff_arr[g] = eff[g*EFF_W +: EFF_W];
  end

  // Strict '>' keeps the earliest candidate in scan order among equals.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    best_eff = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_sum = {1'b0, start_idx} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(N)) begin
        scan_sum = scan_sum - (IDX_W+1)'(N);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (request[scan_idx] && (!found || (eff_arr[scan_idx] > best_eff))) begin
        found    = 1'b1;
        best_eff = eff_arr[scan_idx];
        winner   = scan_idx;
      end
    end
  end

endmodule

// File: rtl/aging_priority_arbiter.sv
// Priority arbiter with per-requester aging boost, round-robin tie-break and optional grant lock.
module aging_priority_arbiter
  import fair_arb_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned PRIORITY_WIDTH = 2,
  parameter int unsigned AGE_WIDTH      = 4,
  parameter int unsigned AGE_THRESHOLD  = 8,
  parameter int unsigned LOCK_ENABLE    = 0,
  localparam int unsigned IDX_W         = idx_w(NUM_REQUESTERS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQUESTERS-1:0]              request,
  input  logic [NUM_REQUESTERS*PRIORITY_WIDTH-1:0] priorities,
  input  logic                                   lock_release,
  output logic [NUM_REQUESTERS-1:0]              grant,
  output logic [IDX_W-1:0]                       grant_idx,
  output logic                                   valid,
  output logic [NUM_REQUESTERS-1:0]              boosted
);

  localparam int unsigned EFF_W = PRIORITY_WIDTH + 1;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
  localparam logic [AGE_WIDTH-1:0] AGE_THR = AGE_WIDTH'(AGE_THRESHOLD);

  arb_state_e                  state_q, state_d;
  logic [NUM_REQUESTERS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]            grant_idx_q, grant_idx_d;
  logic                        valid_q, valid_d;
  logic [NUM_REQUESTERS-1:0]   boosted_q, boosted_d;
  logic [IDX_W-1:0]            last_grant_idx_q, last_grant_idx_d;
  logic [AGE_WIDTH-1:0]        age_q [NUM_REQUESTERS];
  logic [AGE_WIDTH-1:0]        age_d [NUM_REQUESTERS];

  logic [NUM_REQUESTERS*EFF_W-1:0] eff;
  logic [IDX_W-1:0]                start_idx;
  logic [IDX_W-1:0]                winner;
  logic                            found;
  logic [NUM_REQUESTERS-1:0]       winner_oh;
  logic                            hold_drop;

  // Aged requesters sit above every un-aged one regardless of base priority.
  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_eff
    assign eff[i*EFF_W +: EFF_W] =
        {age_q[i] >= AGE_THR, priorities[i*PRIORITY_WIDTH +: PRIORITY_WIDTH]};
  end

  assign start_idx = IDX_W'(wrap_inc(32'(last_grant_idx_q), NUM_REQUESTERS));

  rr_max_select #(
    .N     (NUM_REQUESTERS),
    .EFF_W (EFF_W),
    .IDX_W (IDX_W)
  ) u_select (
    .request   (request),
    .eff       (eff),
    .start_idx (start_idx),
    .winner    (winner),
    .found     (found)
  );

  assign winner_oh = NUM_REQUESTERS'(1) << winner;
  assign hold_drop = lock_release || !request[grant_idx_q];

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    grant_idx_d      = grant_idx_q;
    valid_d          = valid_q;
    last_grant_idx_d = last_grant_idx_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d          = winner_oh;
          grant_idx_d      = winner;
          valid_d          = 1'b1;
          last_grant_idx_d = winner;
          if (LOCK_ENABLE != 0) begin
            state_d = StHold;
          end
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      StHold: begin
        if (hold_drop) begin
          grant_d = '0;
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // A requester granted at this edge (including a lock holder) restarts its wait from zero.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_d[i] || !request[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 1'b1;
      end else begin
        age_d[i] = age_q[i];
      end
      boosted_d[i] = (age_d[i] >= AGE_THR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      grant_q          <= '0;
      grant_idx_q      <= '0;
      valid_q          <= 1'b0;
      boosted_q        <= '0;
      last_grant_idx_q <= IDX_W'(NUM_REQUESTERS - 1);
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      grant_idx_q      <= grant_idx_d;
      valid_q          <= valid_d;
      boosted_q        <= boosted_d;
      last_grant_idx_q <= last_grant_idx_d;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign valid     = valid_q;
  assign boosted   = boosted_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_valid_match  : assert property (@(posedge clk) disable iff (rst) valid_q == (|grant_q));

endmodule
